pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard / redirect / memory-wait controller for a
//               five-stage in-order core. Generates per-stage stall and
//               flush controls from the current FSM state and the live hazard
//               inputs. It also keeps saturating load-use and redirect
//               counters and a sticky data-memory timeout flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   cpu_clk      in   sole clock, rising edge
//   cpu_rst      in   synchronous active-high reset
//   stop         in   load-use hazard request from ID
//   ex_jump      in   taken branch / jal / jalr resolved in EX
//   ex_jump_pc   in   redirect target from EX
//   dmem_req     in   MEM-stage instruction accesses data memory
//   dmem_ready   in   data memory completes the access this cycle
//   pc_stall .. memwb_flush  out  per-stage hold / bubble controls
//   npc_sel, npc out  PC redirect select and target (npc is 0 when unselected)
//   stall_cnt    out  saturating load-use bubble count
//   flush_cnt    out  saturating redirect count
//   mem_err      out  sticky memory-timeout flag
//   state        out  FSM state: RUN=0, MWAIT=1, ERR=2
// ============================================================================
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             stop,
    input  logic             ex_jump,
    input  logic [31:0]      ex_jump_pc,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             memwb_flush,
    output logic             npc_sel,
    output logic [31:0]      npc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err,
    output logic [1:0]       state
);

    // Wide enough to hold MEM_TIMEOUT-1.
    localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic in_err;
    logic mem_wait;
    logic freeze;
    logic do_jump;
    logic do_stop;

    // A wait cycle is only meaningful outside ERR; in ERR the freeze is
    // unconditional and the memory handshake is no longer tracked.
    assign in_err   = (state_q == ST_ERR);
    assign mem_wait = dmem_req & ~dmem_ready & ~in_err;
    assign freeze   = in_err | mem_wait;
    assign do_jump  = ~freeze & ex_jump;
    assign do_stop  = ~freeze & ~ex_jump & stop;

    // ------------------------------------------------------------------
    // Combinational controls; all forced low while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        memwb_flush = 1'b0;
        npc_sel     = 1'b0;
        npc         = 32'd0;
        if (!cpu_rst) begin
            if (freeze) begin
                // Whole front end holds; MEM/WB gets a bubble so the stuck
                // MEM instruction is not retired twice.
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                memwb_flush = 1'b1;
            end else if (do_jump) begin
                npc_sel    = 1'b1;
                npc        = ex_jump_pc;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (do_stop) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mem_err_d   = mem_err_q;
        if (!in_err) begin
            if (mem_wait) begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d   = ST_ERR;
                    mem_err_d = 1'b1;
                end else begin
                    state_d = ST_MWAIT;
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                end
            end else begin
                state_d = ST_RUN;
                wcnt_d  = '0;
                // Counters saturate at all-ones rather than wrapping.
                if (do_jump && !(&flush_cnt_q)) begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
                if (do_stop && !(&stall_cnt_q)) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q     <= ST_RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign mem_err   = mem_err_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Scoreboard bench for pipe_ctrl (MEM_TIMEOUT=4, CNT_W=4).
//               A driver issues one input vector per cycle and pushes the
//               expected response into a queue. A monitor pops and compares
//               each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int TMO   = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst, stop, ex_jump, dmem_req, dmem_ready;
    logic [31:0]   ex_jump_pc;
    logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic          exmem_stall, memwb_flush, npc_sel, mem_err;
    logic [31:0]   npc;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [1:0]    state;

    pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .stop        (stop),
        .ex_jump     (ex_jump),
        .ex_jump_pc  (ex_jump_pc),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .idex_stall  (idex_stall),
        .idex_flush  (idex_flush),
        .exmem_stall (exmem_stall),
        .memwb_flush (memwb_flush),
        .npc_sel     (npc_sel),
        .npc         (npc),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .mem_err     (mem_err),
        .state       (state)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [7:0]  ctrl;   // {pc_stall,ifid_stall,ifid_flush,idex_stall,idex_flush,exmem_stall,memwb_flush,npc_sel}
        logic [31:0] npc;
        int          scnt;
        int          fcnt;
        int          merr;
        int          st;
        bit          chk_regs;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   done  = 0;

    // Reference model: mode 0=run 1=waiting 2=error, plus plain integer counts.
    int m_mode = 0, m_waits = 0, m_scnt = 0, m_fcnt = 0, m_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // One cycle of stimulus plus its expected response.
    task automatic step(input bit rst, input bit stp, input bit jmp, input logic [31:0] pc,
                        input bit req, input bit rdy, input bit regs_known = 1'b1);
        exp_t e;
        bit   frz;
        @(negedge cpu_clk);
        cpu_rst = rst; stop = stp; ex_jump = jmp; ex_jump_pc = pc;
        dmem_req = req; dmem_ready = rdy;

        frz = (m_mode == 2) || (req && !rdy);
        e.ctrl = 8'b0;
        e.npc  = 32'd0;
        if (!rst) begin
            if (frz)       e.ctrl = 8'b1101_0110;
            else if (jmp) begin
                e.ctrl = 8'b0010_1001;
                e.npc  = pc;
            end
            else if (stp)  e.ctrl = 8'b1100_1000;
        end
        e.scnt = m_scnt; e.fcnt = m_fcnt; e.merr = m_err; e.st = m_mode;
        e.chk_regs = regs_known;
        q.push_back(e);

        // Advance the model across the coming rising edge.
        if (rst) begin
            m_mode = 0; m_waits = 0; m_scnt = 0; m_fcnt = 0; m_err = 0;
        end else if (m_mode != 2) begin
            if (req && !rdy) begin
                m_waits++;
                if (m_waits >= TMO) begin
                    m_mode = 2; m_err = 1;
                end else begin
                    m_mode = 1;
                end
            end else begin
                m_mode = 0; m_waits = 0;
                if (jmp)      m_fcnt = (m_fcnt + 1 > CMAX) ? CMAX : m_fcnt + 1;
                else if (stp) m_scnt = (m_scnt + 1 > CMAX) ? CMAX : m_scnt + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0);
    endtask

    // Monitor: compares whatever the driver queued for this cycle.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge cpu_clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ctrl", {24'd0, pc_stall, ifid_stall, ifid_flush, idex_stall,
                             idex_flush, exmem_stall, memwb_flush, npc_sel}, {24'd0, e.ctrl});
                chk("npc", npc, e.npc);
                if (e.chk_regs) begin
                    chk("stall_cnt", {28'd0, stall_cnt}, e.scnt);
                    chk("flush_cnt", {28'd0, flush_cnt}, e.fcnt);
                    chk("mem_err",   {31'd0, mem_err},   e.merr);
                    chk("state",     {30'd0, state},     e.st);
                end
            end
        end
    end

    initial begin
        int len;
        cpu_rst = 1; stop = 0; ex_jump = 0; ex_jump_pc = 0; dmem_req = 0; dmem_ready = 0;

        // Reset with every request asserted; registers unknown before first edge.
        step(1, 1, 1, 32'hDEAD_BEEF, 1, 0, 1'b0);
        step(1, 1, 1, 32'hDEAD_BEEF, 1, 0);
        idle(1);

        // Single load-use bubble.
        step(0, 1, 0, 32'h0, 0, 0);
        idle(1);

        // Jump wins over stop.
        step(0, 1, 1, 32'h0000_1040, 0, 0);
        idle(1);

        // Memory wait with pending jump, then completion takes the redirect.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h0000_2000, 1, 0);
        step(0, 1, 1, 32'h0000_2000, 1, 1);
        idle(1);

        // Timeout into ERR; ready afterwards keeps the freeze; reset recovers.
        for (int i = 0; i < TMO; i++) step(0, 0, 0, 32'h0, 1, 0);
        step(0, 1, 1, 32'h0000_3000, 1, 1);
        step(0, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0);
        idle(1);

        // Stall counter saturation.
        for (int i = 0; i < 20; i++) step(0, 1, 0, 32'h0, 0, 0);
        idle(1);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 32'h0000_0100 + i, 0, 0);
        idle(1);

        // Randomized traffic, with occasional long memory-wait bursts.
        step(1, 0, 0, 32'h0, 0, 0);
        for (int ep = 0; ep < 150; ep++) begin
            if ($urandom_range(0, 5) == 0) begin
                len = $urandom_range(1, TMO + 2);
                for (int k = 0; k < len; k++)
                    step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 1, 0);
            end
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++)
                step($urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 4) == 0, $urandom,
                     $urandom_range(0, 1), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 10) == 0) step(1, 0, 0, 32'h0, 0, 0);
        end

        @(negedge cpu_clk);
        #4;
        done = 1;
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
